// File: rtl/elevator_motion_ctrl_if.sv
// Floor-motion controller bus: request handshake, comparator hookup and car outputs.
// The slave modport is the controller's view; master is the requester/comparator/plant side.
interface elevator_motion_ctrl_if #(
  parameter int FLOOR_W = 2
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;
  logic               equal;
  logic               lower;
  logic               greater;
  logic [FLOOR_W-1:0] current_floor;
  logic [FLOOR_W-1:0] target_floor;
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
  logic               busy;
  logic               cmp_err;
  logic               door_block;

  modport slave (
    input  req_valid, req_floor, equal, lower, greater, door_block,
    output req_ready, current_floor, target_floor, motor_up, motor_down,
           door_open, busy, cmp_err
  );

  modport master (
    output req_valid, req_floor, equal, lower, greater, door_block,
    input  req_ready, current_floor, target_floor, motor_up, motor_down,
           door_open, busy, cmp_err
  );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Timed Moore FSM driving the car between floors from the external comparator's result.
// Optional door-obstruction reopen is enabled by defining ELEVATOR_DOOR_REOPEN_EN.
module elevator_motion_ctrl #(
  parameter int FLOOR_W     = 2,
  parameter int FLOOR_TICKS = 50,
  parameter int DOOR_TICKS  = 100,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  elevator_motion_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EVAL      = 3'd1,
    S_MOVE_UP   = 3'd2,
    S_MOVE_DOWN = 3'd3,
    S_DOOR      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = {FLOOR_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_timer, w_timer_nxt;
  logic [FLOOR_W-1:0] r_floor, w_floor_nxt;
  logic [FLOOR_W-1:0] r_target, w_target_nxt;
  logic               r_err, w_err_nxt;
  logic [CNT_W-1:0]   w_door_tick;

`ifdef ELEVATOR_DOOR_REOPEN_EN
  // An obstructed cycle counts as the first open tick, so the door holds DOOR_TICKS past it.
  assign w_door_tick = bus.door_block ? '0 : r_timer;
`else
  logic w_unused_door_block;
  assign w_unused_door_block = bus.door_block;
  assign w_door_tick         = r_timer;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_floor  <= '0;
      r_target <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_floor  <= w_floor_nxt;
      r_target <= w_target_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer + CNT_W'(1);
    w_floor_nxt  = r_floor;
    w_target_nxt = r_target;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (bus.req_valid) begin
          w_target_nxt = bus.req_floor;
          w_state_nxt  = S_EVAL;
        end
      end
      S_EVAL: begin
        w_timer_nxt = '0;
        case ({bus.equal, bus.lower, bus.greater})
          3'b100:  w_state_nxt = S_DOOR;
          3'b010:  w_state_nxt = S_MOVE_UP;
          3'b001:  w_state_nxt = S_MOVE_DOWN;
          default: begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
      S_MOVE_UP: begin
        if (r_timer == FLOOR_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_EVAL;
          // Saturate at the top rather than wrap; reaching here means the comparator lied.
          if (r_floor == TOP_FLOOR) w_err_nxt = 1'b1;
          else                      w_floor_nxt = r_floor + FLOOR_W'(1);
        end
      end
      S_MOVE_DOWN: begin
        if (r_timer == FLOOR_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_EVAL;
          if (r_floor == '0) w_err_nxt = 1'b1;
          else               w_floor_nxt = r_floor - FLOOR_W'(1);
        end
      end
      S_DOOR: begin
        if (w_door_tick == DOOR_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = w_door_tick + CNT_W'(1);
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready     = 1'b0;
    bus.busy          = 1'b1;
    bus.motor_up      = 1'b0;
    bus.motor_down    = 1'b0;
    bus.door_open     = 1'b0;
    bus.current_floor = r_floor;
    bus.target_floor  = r_target;
    bus.cmp_err       = r_err;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      S_MOVE_UP:   bus.motor_up   = 1'b1;
      S_MOVE_DOWN: bus.motor_down = 1'b1;
      S_DOOR:      bus.door_open  = 1'b1;
      default:     bus.busy       = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: per-request expected traces built from floor-travel rules,
// with a behavioural comparator, random requests, busy-time noise and forced illegal compares.
module tb_elevator_motion_ctrl;
  localparam int FT = 4;
  localparam int DT = 3;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       up;
    logic       dn;
    logic       door;
    logic       err;
    logic [1:0] cf;
    logic [1:0] tf;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elevator_motion_ctrl_if #(.FLOOR_W(2)) bus ();

  elevator_motion_ctrl #(
    .FLOOR_W(2), .FLOOR_TICKS(FT), .DOOR_TICKS(DT), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic       force_on;
  logic [2:0] forced;
  assign bus.equal   = force_on ? forced[2] : (bus.current_floor == bus.target_floor);
  assign bus.lower   = force_on ? forced[1] : (bus.current_floor <  bus.target_floor);
  assign bus.greater = force_on ? forced[0] : (bus.current_floor >  bus.target_floor);

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] m_cf;
  logic       m_err;

  function automatic obs_t mk(input logic rdy, input logic busy, input logic up, input logic dn,
                              input logic door, input logic err, input logic [1:0] cf,
                              input logic [1:0] tf);
    obs_t o;
    o.rdy = rdy; o.busy = busy; o.up = up; o.dn = dn;
    o.door = door; o.err = err; o.cf = cf; o.tf = tf;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.req_ready, bus.busy, bus.motor_up, bus.motor_down,
              bus.door_open, bus.cmp_err, bus.current_floor, bus.target_floor);
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t o;
    o = sample();
    checks++;
    assert (o === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  // Issue one request from a negedge and follow it cycle by cycle until IDLE again.
  task automatic run_req(input string tag, input logic [1:0] t, input bit noise, input bit blk);
    obs_t       q[$];
    logic [1:0] c;
    logic [1:0] tf_exp;
    int         door_first;
    int         n_door;
    bit         up;
    c          = m_cf;
    tf_exp     = t;
    door_first = -10;
    q.push_back(mk(0, 1, 0, 0, 0, m_err, c, tf_exp));
    if (force_on) begin
      m_err = 1'b1;
      q.push_back(mk(1, 0, 0, 0, 0, 1, c, tf_exp));
    end else begin
      while (c != t) begin
        up = (t > c);
        repeat (FT) q.push_back(mk(0, 1, up, !up, 0, m_err, c, tf_exp));
        c = up ? c + 2'd1 : c - 2'd1;
        q.push_back(mk(0, 1, 0, 0, 0, m_err, c, tf_exp));
      end
      door_first = q.size();
      n_door     = DT;
`ifdef ELEVATOR_DOOR_REOPEN_EN
      if (blk) n_door = 1 + DT;
`endif
      repeat (n_door) q.push_back(mk(0, 1, 0, 0, 1, m_err, c, tf_exp));
      q.push_back(mk(1, 0, 0, 0, 0, m_err, c, tf_exp));
    end
    m_cf = c;
    bus.req_valid = 1'b1;
    bus.req_floor = t;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, k), q[k]);
      bus.req_valid  = noise && (k + 1 < q.size()) && ($urandom_range(0, 2) == 0);
      bus.req_floor  = 2'($urandom_range(0, 3));
      bus.door_block = blk && (k == door_first + 1);
    end
    bus.req_valid  = 1'b0;
    bus.door_block = 1'b0;
  endtask

  initial begin
    logic [1:0] t;
    obs_t       o;
    rst_n          = 1'b0;
    force_on       = 1'b0;
    forced         = 3'b000;
    bus.req_valid  = 1'b0;
    bus.req_floor  = 2'd0;
    bus.door_block = 1'b0;
    m_cf           = 2'd0;
    m_err          = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_state", mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", mk(1, 0, 0, 0, 0, 0, 0, 0));

    run_req("up_0_to_2", 2'd2, 1'b0, 1'b0);
    run_req("down_2_to_1", 2'd1, 1'b0, 1'b0);
    run_req("same_floor_1", 2'd1, 1'b0, 1'b0);
    run_req("up_1_to_3", 2'd3, 1'b0, 1'b0);
    run_req("down_3_to_0", 2'd0, 1'b1, 1'b0);
    run_req("door_block", 2'd0, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      t = 2'($urandom_range(0, 3));
      run_req($sformatf("rand%0d", i), t, 1'b1, 1'($urandom_range(0, 1)));
    end

    force_on = 1'b1;
    forced   = 3'b110;
    run_req("illegal_eq_lt", 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    forced   = 3'b000;
    run_req("illegal_none", 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    force_on = 1'b0;
    run_req("err_sticky", 2'($urandom_range(0, 3)), 1'b1, 1'b0);

    // Abort a move with reset.
    run_req("to_floor0", 2'd0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_floor = 2'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_moving", mk(0, 1, 1, 0, 0, m_err, 0, 3));
    rst_n = 1'b0;
    #1;
    o = mk(1, 0, 0, 0, 0, 0, 0, 0);
    check("async_reset_midmove", o);
    @(negedge clk);
    rst_n = 1'b1;
    m_cf  = 2'd0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_req("after_reset_up", 2'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
Floor-motion controller for the elevator car. It sits directly downstream of the 2-bit floor comparator. It owns the current-floor register, which feeds comparator DataA, and the latched target floor, which feeds comparator DataB. It consumes the comparator's equal/lower/greater outputs to drive the motor up/down outputs and the door-open output through a timed Moore FSM.

Parameters:
FLOOR_W, 2, floor index width; must match comparator width; top floor = 2**FLOOR_W-1
FLOOR_TICKS, 50, clock cycles spent in a MOVE state per floor travelled (>=1)
DOOR_TICKS, 100, clock cycles the door stays open (>=1)
CNT_W, 8, timer width; must hold max(FLOOR_TICKS, DOOR_TICKS)-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  floor request present
req_floor  in  FLOOR_W  requested floor
req_ready  out  1  controller can accept a request (high only in IDLE)
equal  in  1  comparator: current_floor == target_floor
lower  in  1  comparator: current_floor < target_floor
greater  in  1  comparator: current_floor > target_floor
current_floor  out  FLOOR_W  registered car position, wired to comparator DataA
target_floor  out  FLOOR_W  latched request, wired to comparator DataB
motor_up  out  1  drive car upward
motor_down  out  1  drive car downward
door_open  out  1  door held open
busy  out  1  high in every state except IDLE
cmp_err  out  1  sticky: illegal comparator combination seen
door_block  in  1  obstruction sensor (used only with the optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; current_floor=0, target_floor=0, timer=0.
  - motor_up, motor_down, door_open, busy and cmp_err are all 0; req_ready=1.
  - Reset asserted mid-move or with the door open aborts immediately.
- All outputs are registered or decoded from registered state (Moore); no combinational path from inputs to outputs.
- States: IDLE, EVAL, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE:
  - req_ready=1.
  - When req_valid=1: latch target_floor<=req_floor and go to EVAL. Acceptance takes one cycle.
  - When req_valid=0: requests are ignored.
- EVAL (1 cycle; comparator inputs are settled from the registered floors):
  - lower only -> MOVE_UP.
  - greater only -> MOVE_DOWN.
  - equal only -> DOOR.
  - Any other combination (none asserted, or more than one) -> cmp_err<=1 (sticky until reset), go to IDLE, no motion.
- MOVE_UP / MOVE_DOWN:
  - motor_up / motor_down = 1 respectively, never both.
  - timer counts 0..FLOOR_TICKS-1.
  - On the edge after timer==FLOOR_TICKS-1: current_floor +1 / -1, timer<=0, go to EVAL.
- DOOR:
  - door_open=1; timer counts 0..DOOR_TICKS-1.
  - On the edge after timer==DOOR_TICKS-1: go to IDLE.
- Timer is cleared on every state entry.
- Requests arriving while busy are not accepted (req_ready=0). The requester must hold req_valid; there is no queue.
- current_floor never wraps: an increment at the top floor or a decrement at floor 0 is blocked. If such a move is ever attempted, the floor saturates and cmp_err<=1.
- Timing: a move of N floors from request acceptance to door_open takes 1 + N*(FLOOR_TICKS+1) + 1 edges.

Optional Feature:
- Macro: ELEVATOR_DOOR_REOPEN_EN.
- Defined: in DOOR, door_block=1 resets the timer to 0 each cycle. The door closes DOOR_TICKS cycles after door_block was last high.
- Undefined: door_block is ignored; door_open is high for exactly DOOR_TICKS cycles.
- The port exists in both builds.

Test Plan:
- Reset: rst_n=0 mid-MOVE_UP -> all outputs 0 immediately, current_floor=0, req_ready=1. After release the controller idles.
- Up travel (FLOOR_TICKS=4, DOOR_TICKS=3): from floor 0, req_floor=2 accepted at edge 0:
  - EVAL at edge 1; motor_up high edges 2-5.
  - current_floor=1 at edge 6; motor_up again edges 7-10.
  - current_floor=2 at edge 11; door_open high edges 12-14; IDLE with req_ready=1 at edge 15.
- Down travel: from floor 3, req_floor=0 -> motor_down for 3 floors, current_floor 3->2->1->0, motor_up never asserted, then door_open.
- Same floor: at floor 1, req_floor=1 -> EVAL then DOOR directly; no motor output; door_open for exactly 3 cycles.
- Busy and illegal compare:
  - req_valid pulsed during MOVE -> ignored; target_floor unchanged.
  - Force equal=lower=1 in EVAL -> cmp_err=1 (sticky), return to IDLE, no motion.
- Door reopen: with the macro, door_block high in the 2nd DOOR cycle -> door_open lasts 1+3 cycles. Without the macro -> 3 cycles.
